// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode/funct
// fields and the datapath select encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010,
    ALU_SUB = 3'b110, ALU_SLT = 3'b111
  } alu_e;

  typedef enum logic [1:0] {
    SRCB_RD2 = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMMSH = 2'b11
  } srcb_e;

  typedef enum logic [1:0] {
    PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10
  } pcsrc_e;

  typedef enum logic [1:0] {
    AOP_ADD = 2'b00, AOP_SUB = 2'b01, AOP_FUNCT = 2'b10
  } aluop_e;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps the FSM's ALU intent plus the funct field to an
// alucontrol code, flagging funct values with no defined operation.
module aludec
  import mc_pkg::*;
(
  input  aluop_e      aluop_i,
  input  logic  [5:0] funct_i,
  output logic  [2:0] alucontrol_o,
  output logic        bad_funct_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    bad_funct_o  = 1'b0;
    case (aluop_i)
      AOP_SUB: alucontrol_o = ALU_SUB;
      AOP_FUNCT: begin
        case (funct_i)
          F_ADD:   alucontrol_o = ALU_ADD;
          F_SUB:   alucontrol_o = ALU_SUB;
          F_AND:   alucontrol_o = ALU_AND;
          F_OR:    alucontrol_o = ALU_OR;
          F_SLT:   alucontrol_o = ALU_SLT;
          default: bad_funct_o  = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-style control unit: Moore FSM with handshake-qualified
// fetch/memory strobes, branch-qualified pcen and a retired-instruction counter.
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned WAIT_MEM = 1,
  parameter int unsigned EXT_ISA  = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic             pcen,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             rdy, ext, bad_funct, retire;
  logic             mreq_c, mw_c, irw_c, rw_c, pcw_c, br_c;
  aluop_e           aluop;

  assign rdy = (WAIT_MEM != 0) ? mem_ready : 1'b1;
  assign ext = (EXT_ISA != 0);

  // ALU intent depends only on state so the decoder never loops back on itself
  assign aluop = (state_q == S_RTYPEEX) ? AOP_FUNCT :
                 (state_q == S_BEQEX)   ? AOP_SUB   : AOP_ADD;

  aludec u_aludec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol),
    .bad_funct_o  (bad_funct)
  );

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    mreq_c   = 1'b0;
    mw_c     = 1'b0;
    irw_c    = 1'b0;
    rw_c     = 1'b0;
    pcw_c    = 1'b0;
    br_c     = 1'b0;
    iord     = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_RD2;
    pcsrc    = PC_ALU;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mreq_c  = 1'b1;
        alusrcb = SRCB_FOUR;
        irw_c   = rdy;
        pcw_c   = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        if (op == OP_LW || op == OP_SW)                  state_d = S_MEMADR;
        else if (op == OP_RTYPE)                         state_d = S_RTYPEEX;
        else if (op == OP_BEQ || (ext && op == OP_BNE))  state_d = S_BEQEX;
        else if (ext && op == OP_ADDI)                   state_d = S_ADDIEX;
        else if (ext && op == OP_J)                      state_d = S_JEX;
        else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mreq_c = 1'b1;
        iord   = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        rw_c     = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mreq_c = 1'b1;
        iord   = 1'b1;
        mw_c   = 1'b1;
        if (rdy) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        if (bad_funct) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_RTYPEWB;
        end
      end
      S_RTYPEWB: begin
        regdst  = 1'b1;
        rw_c    = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        pcsrc   = PC_ALUOUT;
        br_c    = (op == OP_BNE) ? ~zero : zero;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        rw_c    = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JEX: begin
        pcsrc   = PC_JUMP;
        pcw_c   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Side-effecting strobes are suppressed while reset is held, whatever the state
  assign mem_req  = mreq_c & reset;
  assign memwrite = mw_c & reset;
  assign irwrite  = irw_c & reset;
  assign regwrite = rw_c & reset;
  assign pcen     = (pcw_c | br_c) & reset;
  assign instret  = instret_q;

endmodule

// File: tb/tb_mc_controller.sv
// Randomised bench for mc_controller: two configurations driven from an
// instruction-level model of the control sequence, compared every cycle.
module tb_mc_controller;

  typedef struct packed {
    logic        mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0]  alusrcb;
    logic [1:0]  pcsrc;
    logic [2:0]  alucontrol;
    logic        illegal;
    logic [31:0] instret;
  } ov_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000, JMP = 6'b000010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a [2];
  logic [5:0] op_a  [2];
  logic [5:0] fn_a  [2];
  logic       z_a   [2];
  logic       rdy_a [2];

  logic       mreq [2], iord [2], mw [2], irw [2], rdst [2], m2r [2], rw [2], asa [2], pcen [2], ill [2];
  logic [1:0] srcb [2];
  logic [1:0] pcs  [2];
  logic [2:0] aluc [2];
  logic [3:0]  ir0;
  logic [31:0] ir1;
  ov_t obs [2];

  // dut0: handshake honoured, extended ISA, 4-bit counter
  mc_controller #(.WAIT_MEM(1), .EXT_ISA(1), .CNT_W(4)) dut0 (
    .clk(clk), .reset(rst_a[0]), .op(op_a[0]), .funct(fn_a[0]), .zero(z_a[0]),
    .mem_ready(rdy_a[0]), .mem_req(mreq[0]), .iord(iord[0]), .memwrite(mw[0]),
    .irwrite(irw[0]), .regdst(rdst[0]), .memtoreg(m2r[0]), .regwrite(rw[0]),
    .alusrca(asa[0]), .pcen(pcen[0]), .alusrcb(srcb[0]), .pcsrc(pcs[0]),
    .alucontrol(aluc[0]), .illegal(ill[0]), .instret(ir0));

  // dut1: zero-wait memory, base ISA only, 32-bit counter
  mc_controller #(.WAIT_MEM(0), .EXT_ISA(0), .CNT_W(32)) dut1 (
    .clk(clk), .reset(rst_a[1]), .op(op_a[1]), .funct(fn_a[1]), .zero(z_a[1]),
    .mem_ready(rdy_a[1]), .mem_req(mreq[1]), .iord(iord[1]), .memwrite(mw[1]),
    .irwrite(irw[1]), .regdst(rdst[1]), .memtoreg(m2r[1]), .regwrite(rw[1]),
    .alusrca(asa[1]), .pcen(pcen[1]), .alusrcb(srcb[1]), .pcsrc(pcs[1]),
    .alucontrol(aluc[1]), .illegal(ill[1]), .instret(ir1));

  assign obs[0] = {mreq[0], iord[0], mw[0], irw[0], rdst[0], m2r[0], rw[0], asa[0], pcen[0],
                   srcb[0], pcs[0], aluc[0], ill[0], {28'd0, ir0}};
  assign obs[1] = {mreq[1], iord[1], mw[1], irw[1], rdst[1], m2r[1], rw[1], asa[1], pcen[1],
                   srcb[1], pcs[1], aluc[1], ill[1], ir1};

  int          checks = 0, errors = 0, cyc_n = 0, act_d = 0;
  bit          chk_en = 1'b0;
  ov_t         exp_o;
  int unsigned cnt [2];

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (obs[act_d] !== exp_o) begin
        errors++;
        $display("FAIL cycle dut%0d t=%0t {strobes,srcb,pcsrc,alu,ill,instret} got=%h exp=%h",
                 act_d, $time, obs[act_d], exp_o);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, expv);
    end
  endtask

  function automatic bit wm(input int d);  return d == 0; endfunction
  function automatic bit ext(input int d); return d == 0; endfunction
  function automatic int unsigned msk(input int d); return (d == 0) ? 32'hF : 32'hFFFF_FFFF; endfunction

  function automatic bit legal(input int d, input logic [5:0] o);
    if (o == LW || o == SW || o == RT || o == BEQ) return 1'b1;
    return ext(d) && (o == ADDI || o == BNE || o == JMP);
  endfunction

  function automatic ov_t base();
    ov_t e = '0;
    e.alucontrol = 3'b010;
    return e;
  endfunction

  // One clock of the reference: drive inputs, publish expectation, advance model count
  task automatic step(input int d, input logic r, input logic z, input logic rl, input ov_t e, input bit ret);
    rst_a[d] = rl; rdy_a[d] = r; z_a[d] = z;
    if (!rl) begin
      e.memwrite = 1'b0; e.regwrite = 1'b0; e.irwrite = 1'b0; e.pcen = 1'b0; e.mem_req = 1'b0;
    end
    e.instret = cnt[d] & msk(d);
    exp_o = e; act_d = d; chk_en = 1'b1;
    @(posedge clk); #1;
    cyc_n++;
    if (!rl) cnt[d] = 0;
    else if (ret) cnt[d] = (cnt[d] + 1) & msk(d);
  endtask

  // A memory access held for 'waits' not-ready cycles (none if memory is always ready)
  task automatic mem_phase(input int d, input int waits, input ov_t e, input bit is_fetch, input bit ret_end);
    int n;
    n = wm(d) ? waits : 0;
    for (int k = 0; k <= n; k++) begin
      ov_t x;
      logic done, r;
      x = e;
      done = (k == n);
      r = wm(d) ? done : 1'($urandom);
      if (is_fetch) begin x.irwrite = done; x.pcen = done; end
      step(d, r, 1'($urandom), 1'b1, x, ret_end && done);
    end
  endtask

  task automatic run_instr(input int d, input logic [5:0] o, input logic [5:0] f, input logic zb,
                           input int wf, input int wmem);
    ov_t e;
    logic [2:0] ac;
    bit bad;
    op_a[d] = o; fn_a[d] = f;
    e = base(); e.mem_req = 1'b1; e.alusrcb = 2'b01;
    mem_phase(d, wf, e, 1'b1, 1'b0);
    e = base(); e.alusrcb = 2'b11;
    if (!legal(d, o)) begin
      e.illegal = 1'b1;
      step(d, 1'($urandom), 1'($urandom), 1'b1, e, 1'b0);
      return;
    end
    step(d, 1'($urandom), 1'($urandom), 1'b1, e, 1'b0);
    e = base();
    if (o == LW || o == SW) begin
      e.alusrca = 1'b1; e.alusrcb = 2'b10;
      step(d, 1'($urandom), 1'($urandom), 1'b1, e, 1'b0);
      e = base(); e.mem_req = 1'b1; e.iord = 1'b1;
      if (o == SW) begin
        e.memwrite = 1'b1;
        mem_phase(d, wmem, e, 1'b0, 1'b1);
      end else begin
        mem_phase(d, wmem, e, 1'b0, 1'b0);
        e = base(); e.memtoreg = 1'b1; e.regwrite = 1'b1;
        step(d, 1'($urandom), 1'($urandom), 1'b1, e, 1'b1);
      end
    end else if (o == RT) begin
      bad = 1'b0;
      case (f)
        6'b100000: ac = 3'b010;
        6'b100010: ac = 3'b110;
        6'b100100: ac = 3'b000;
        6'b100101: ac = 3'b001;
        6'b101010: ac = 3'b111;
        default: begin ac = 3'b010; bad = 1'b1; end
      endcase
      e.alusrca = 1'b1; e.alucontrol = ac; e.illegal = bad;
      step(d, 1'($urandom), 1'($urandom), 1'b1, e, 1'b0);
      if (!bad) begin
        e = base(); e.regdst = 1'b1; e.regwrite = 1'b1;
        step(d, 1'($urandom), 1'($urandom), 1'b1, e, 1'b1);
      end
    end else if (o == BEQ || o == BNE) begin
      e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
      e.pcen = (o == BEQ) ? zb : ~zb;
      step(d, 1'($urandom), zb, 1'b1, e, 1'b1);
    end else if (o == ADDI) begin
      e.alusrca = 1'b1; e.alusrcb = 2'b10;
      step(d, 1'($urandom), 1'($urandom), 1'b1, e, 1'b0);
      e = base(); e.regwrite = 1'b1;
      step(d, 1'($urandom), 1'($urandom), 1'b1, e, 1'b1);
    end else begin
      e.pcsrc = 2'b10; e.pcen = 1'b1;
      step(d, 1'($urandom), 1'($urandom), 1'b1, e, 1'b1);
    end
  endtask

  task automatic rand_instr(input int d);
    logic [5:0] o, f;
    logic [5:0] ops [7];
    logic [5:0] fns [5];
    ops = '{LW, SW, RT, BEQ, BNE, ADDI, JMP};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    o = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
    f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
    run_instr(d, o, f, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  // Store interrupted by reset while waiting on memory: no write, counter cleared
  task automatic sw_reset(input int d);
    ov_t e;
    op_a[d] = SW; fn_a[d] = 6'($urandom);
    e = base(); e.mem_req = 1'b1; e.alusrcb = 2'b01;
    mem_phase(d, 0, e, 1'b1, 1'b0);
    e = base(); e.alusrcb = 2'b11;
    step(d, 1'b0, 1'b0, 1'b1, e, 1'b0);
    e = base(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
    step(d, 1'b0, 1'b0, 1'b1, e, 1'b0);
    e = base(); e.mem_req = 1'b1; e.iord = 1'b1; e.memwrite = 1'b1;
    step(d, 1'b0, 1'b0, 1'b1, e, 1'b0);
    step(d, 1'b0, 1'b0, 1'b1, e, 1'b0);
    step(d, 1'b1, 1'b0, 1'b0, e, 1'b0);
    e = base(); e.mem_req = 1'b1; e.alusrcb = 2'b01;
    step(d, 1'b1, 1'b0, 1'b0, e, 1'b0);
  endtask

  initial begin
    ov_t e;
    int c0;
    for (int d = 0; d < 2; d++) begin
      rst_a[d] = 1'b0; op_a[d] = '0; fn_a[d] = '0; z_a[d] = 1'b0; rdy_a[d] = 1'b0; cnt[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    e = base(); e.mem_req = 1'b1; e.alusrcb = 2'b01;
    step(0, 1'b1, 1'b0, 1'b0, e, 1'b0);

    // store held 3 cycles by memory, then branch/R-type/ext directed cases
    c0 = cyc_n; run_instr(0, SW, 6'd0, 1'b0, 0, 3);
    lit("sw_wait3_cycles", cyc_n - c0, 7);
    lit("instret_after_sw", obs[0].instret, 1);
    c0 = cyc_n; run_instr(0, BEQ, 6'd0, 1'b1, 0, 0); lit("beq_cycles", cyc_n - c0, 3);
    run_instr(0, BNE, 6'd0, 1'b1, 0, 0);
    run_instr(0, BNE, 6'd0, 1'b0, 0, 0);
    c0 = cyc_n; run_instr(0, RT, 6'b101010, 1'b0, 0, 0); lit("rtype_cycles", cyc_n - c0, 4);
    c0 = cyc_n; run_instr(0, RT, 6'b000111, 1'b0, 0, 0); lit("bad_funct_cycles", cyc_n - c0, 3);
    c0 = cyc_n; run_instr(0, ADDI, 6'd0, 1'b0, 0, 0); lit("addi_cycles", cyc_n - c0, 4);
    c0 = cyc_n; run_instr(0, JMP, 6'd0, 1'b0, 0, 0); lit("j_cycles", cyc_n - c0, 3);
    c0 = cyc_n; run_instr(0, LW, 6'd0, 1'b0, 0, 0); lit("lw_cycles", cyc_n - c0, 5);
    lit("instret_after_directed", obs[0].instret, 8);

    for (int i = 0; i < 40; i++) rand_instr(0);
    while (cnt[0] != 15) run_instr(0, JMP, 6'd0, 1'b0, 0, 0);
    lit("instret_at_15", obs[0].instret, 15);
    run_instr(0, JMP, 6'd0, 1'b0, 0, 0);
    lit("instret_wrap", obs[0].instret, 0);
    run_instr(0, JMP, 6'd0, 1'b0, 1, 0);
    sw_reset(0);
    lit("instret_after_reset", obs[0].instret, 0);
    run_instr(0, LW, 6'd0, 1'b0, 2, 2);

    // zero-wait, base-ISA configuration
    chk_en = 1'b0;
    rst_a[0] = 1'b0;
    e = base(); e.mem_req = 1'b1; e.alusrcb = 2'b01;
    step(1, 1'b0, 1'b0, 1'b0, e, 1'b0);
    c0 = cyc_n; run_instr(1, LW, 6'd0, 1'b0, 3, 3);
    lit("lw_zero_wait_cycles", cyc_n - c0, 5);
    lit("instret_after_lw", obs[1].instret, 1);
    c0 = cyc_n; run_instr(1, ADDI, 6'd0, 1'b0, 0, 0);
    lit("addi_illegal_cycles", cyc_n - c0, 2);
    c0 = cyc_n; run_instr(1, SW, 6'd0, 1'b0, 3, 3); lit("sw_zero_wait_cycles", cyc_n - c0, 4);
    run_instr(1, BNE, 6'd0, 1'b0, 0, 0);
    run_instr(1, RT, 6'b100010, 1'b0, 0, 0);
    lit("instret_dut1", obs[1].instret, 3);
    for (int i = 0; i < 40; i++) rand_instr(1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
